// File: rtl/uart_debug_responder.sv
// UART debug preload responder: parses CMD/ADDR/COUNT frames from the RX byte stream, performs 64-bit memory
// reads/writes and answers with ACK/NAK/read data. Optional inter-byte timeout via UART_DEBUG_RESPONDER_TIMEOUT_EN.
module uart_debug_responder #(
  parameter int unsigned AddrWidth     = 64,
  parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [63:0]          mem_wdata_o,
  output logic [7:0]           mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [63:0]          mem_rdata_i,
  output logic                 busy_o
);

  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    IDLE, HDR_ADDR, HDR_LEN, WR_DATA, WR_REQ, WR_WAIT,
    RD_ACK, RD_REQ, RD_WAIT, RD_DATA, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [63:0] word_q, word_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  resp_q, resp_d;
  logic        is_wr_q, is_wr_d;

  logic        rx_fire, tx_fire;
  logic [31:0] count_shift;
  logic        tmo_hit;

  // rx_ready is gated by reset so every output except be reads 0 while reset is held.
  assign rx_ready_o  = !rst_i && (state_q inside {IDLE, HDR_ADDR, HDR_LEN, WR_DATA});
  assign tx_valid_o  = state_q inside {RD_ACK, RD_DATA, RESP};
  assign mem_req_o   = state_q inside {WR_REQ, RD_REQ};
  assign mem_we_o    = (state_q == WR_REQ);
  assign mem_addr_o  = {addr_q[AddrWidth-1:3], 3'b000};
  assign mem_wdata_o = word_q;
  assign mem_be_o    = 8'hFF;
  assign busy_o      = (state_q != IDLE);

  assign rx_fire     = rx_valid_i && rx_ready_o;
  assign tx_fire     = tx_valid_o && tx_ready_i;
  assign count_shift = {rx_data_i, count_q[31:8]};

  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      RD_ACK:  tx_data_o = ACK;
      RD_DATA: tx_data_o = word_q[7:0];
      RESP:    tx_data_o = resp_q;
      default: tx_data_o = 8'h00;
    endcase
  end

`ifdef UART_DEBUG_RESPONDER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        waiting;

  assign waiting = state_q inside {HDR_ADDR, HDR_LEN, WR_DATA};

  always_comb begin
    tmo_d = 32'd0;
    if (waiting && !rx_fire) tmo_d = tmo_q + 32'd1;
  end

  assign tmo_hit = waiting && !rx_fire && (tmo_d == TimeoutCycles);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= 32'd0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    resp_d  = resp_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        is_wr_d = (rx_data_i == CMD_WR);
        bcnt_d  = 3'd0;
        if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
          state_d = HDR_ADDR;
        end else begin
          resp_d  = NAK;
          state_d = RESP;
        end
      end
      HDR_ADDR: if (rx_fire) begin
        addr_d = {rx_data_i, addr_q[63:8]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          addr_d[2:0] = 3'b000;
          state_d     = HDR_LEN;
        end
      end
      HDR_LEN: if (rx_fire) begin
        count_d = count_shift;
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd3) begin
          bcnt_d = 3'd0;
          if (count_shift == 32'd0) begin
            resp_d  = ACK;
            state_d = RESP;
          end else if (is_wr_q) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_ACK;
          end
        end
      end
      WR_DATA: if (rx_fire) begin
        word_d = {rx_data_i, word_q[63:8]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = WR_REQ;
      end
      WR_REQ: if (mem_gnt_i) state_d = WR_WAIT;
      WR_WAIT: if (mem_rvalid_i) begin
        addr_d  = addr_q + 64'd8;
        count_d = count_q - 32'd1;
        if (count_q == 32'd1) begin
          resp_d  = ACK;
          state_d = RESP;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_ACK: if (tx_fire) state_d = RD_REQ;
      RD_REQ: if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) begin
        word_d  = mem_rdata_i;
        bcnt_d  = 3'd0;
        state_d = RD_DATA;
      end
      RD_DATA: if (tx_fire) begin
        word_d = {8'h00, word_q[63:8]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          addr_d  = addr_q + 64'd8;
          count_d = count_q - 32'd1;
          state_d = (count_q == 32'd1) ? IDLE : RD_REQ;
        end
      end
      RESP: if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stalled host abandons the partial frame and gets a NAK.
    if (tmo_hit) begin
      resp_d  = NAK;
      bcnt_d  = 3'd0;
      state_d = RESP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 64'd0;
      count_q <= 32'd0;
      word_q  <= 64'd0;
      bcnt_q  <= 3'd0;
      resp_q  <= 8'h00;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      resp_q  <= resp_d;
      is_wr_q <= is_wr_d;
    end
  end

endmodule

// File: tb/tb_uart_debug_responder.sv
// Self-checking bench: host frames, randomized memory/TX timing and a queue-based reference model.
module tb_uart_debug_responder;

`ifdef UART_DEBUG_RESPONDER_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd100;
`else
  localparam logic [31:0] TMO = 32'd1_000_000;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        busy_o;

  uart_debug_responder #(.AddrWidth(64), .TimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } op_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx[$];
  op_t         exp_ops[$];
  logic [63:0] model_mem[logic [63:0]];
  logic [63:0] phys_mem[logic [63:0]];
  logic [63:0] wq[$];
  int          tx_stall  = 0;
  int          gnt_force = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  // Memory: random grant latency, rvalid 1..3 cycles after grant, occasional stray rvalid.
  initial begin : mem_model
    int wcnt, gdel, rvd;
    logic pend;
    logic [63:0] prd, snap_a, snap_wd;
    logic snap_we;
    op_t o;
    wcnt = 0; gdel = 0; rvd = 0; pend = 1'b0; prd = '0;
    snap_a = '0; snap_wd = '0; snap_we = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rst_i) begin
        pend = 1'b0; wcnt = 0;
        continue;
      end
      if (pend) begin
        if (rvd == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = prd; pend = 1'b0;
        end else rvd--;
      end else if (mem_req_o) begin
        if (wcnt == 0) begin
          snap_a = mem_addr_o; snap_we = mem_we_o; snap_wd = mem_wdata_o;
          gdel = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 3));
        end else begin
          chk("req_addr_stable", mem_addr_o, snap_a);
          chk("req_we_stable", mem_we_o, snap_we);
          if (snap_we) chk("req_wdata_stable", mem_wdata_o, snap_wd);
        end
        if (wcnt >= gdel) begin
          mem_gnt_i = 1'b1; wcnt = 0;
          chk("op_expected", exp_ops.size() > 0, 1);
          if (exp_ops.size() > 0) begin
            o = exp_ops.pop_front();
            chk("op_addr", mem_addr_o, o.addr);
            chk("op_we", mem_we_o, o.we);
            chk("op_be", mem_be_o, 8'hFF);
            if (o.we) chk("op_wdata", mem_wdata_o, o.wdata);
          end
          if (mem_we_o) phys_mem[mem_addr_o] = mem_wdata_o;
          else prd = phys_mem.exists(mem_addr_o) ? phys_mem[mem_addr_o] : fill(mem_addr_o);
          pend = 1'b1;
          rvd = $urandom_range(0, 2);
        end else wcnt++;
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = {$urandom, $urandom};
      end
    end
  end

  // TX sink: random ready, optional forced stall, checks hold-while-stalled and byte order.
  initial begin : tx_sink
    logic prev_stall;
    logic [7:0] prev_dat;
    prev_stall = 1'b0; prev_dat = '0;
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 1'b0; tx_ready_i = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("tx_hold_valid", tx_valid_o, 1);
        chk("tx_hold_data", tx_data_o, prev_dat);
      end
      if (tx_stall > 0) begin
        tx_ready_i = 1'b0;
        if (tx_valid_o) tx_stall--;
      end else tx_ready_i = ($urandom_range(0, 3) != 0);
      if (tx_valid_o || mem_req_o) chk("rx_ready_low_while_pending", rx_ready_o, 0);
      if (tx_valid_o && tx_ready_i) begin
        chk("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_data_o, exp_tx.pop_front());
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_dat = tx_data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_i);
    rx_valid_i = 1'b1; rx_data_i = b;
    while (!rx_ready_o && n < 3000) begin
      @(negedge clk_i); n++;
    end
    if (n >= 3000) chk("rx_accept_timeout", rx_ready_o, 1);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [63:0] a, input logic [31:0] c);
    send_byte(cmd);
    for (int k = 0; k < 8; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(c[8*k +: 8]);
  endtask

  task automatic send_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic expect_writes(input logic [63:0] a, input int n);
    logic [63:0] wa;
    for (int i = 0; i < n; i++) begin
      wa = {a[63:3], 3'b000} + 64'(8 * i);
      exp_ops.push_back('{addr: wa, we: 1'b1, wdata: wq[i]});
      model_mem[wa] = wq[i];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_ops.size() != 0 || busy_o) && n < 5000) begin
      @(negedge clk_i); n++;
    end
    chk("frame_tx_drained", exp_tx.size(), 0);
    chk("frame_ops_drained", exp_ops.size(), 0);
    chk("frame_idle", busy_o, 0);
  endtask

  task automatic do_write(input logic [63:0] a, input int c);
    expect_writes(a, c);
    exp_tx.push_back(8'h06);
    send_hdr(8'h01, a, 32'(c));
    send_words(c);
    wait_idle();
  endtask

  task automatic push_read(input logic [63:0] a, input int c);
    logic [63:0] ra, d;
    exp_tx.push_back(8'h06);
    for (int i = 0; i < c; i++) begin
      ra = {a[63:3], 3'b000} + 64'(8 * i);
      exp_ops.push_back('{addr: ra, we: 1'b0, wdata: 64'd0});
      d = model_mem.exists(ra) ? model_mem[ra] : fill(ra);
      for (int k = 0; k < 8; k++) exp_tx.push_back(d[8*k +: 8]);
    end
  endtask

  task automatic do_read(input logic [63:0] a, input int c);
    push_read(a, c);
    send_hdr(8'h02, a, 32'(c));
    wait_idle();
  endtask

  task automatic new_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back({$urandom, $urandom});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready_o, 0);
    chk({tag, "_tx_valid"}, tx_valid_o, 0);
    chk({tag, "_tx_data"}, tx_data_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_be"}, mem_be_o, 8'hFF);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check_reset_outputs("midreset");
    exp_tx.delete();
    exp_ops.delete();
    tx_stall = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset_rx_ready", rx_ready_o, 1);
  endtask

  initial begin : main
    int n, r, c;
    logic [7:0] b;
    logic [63:0] a;
    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_rx_ready", rx_ready_o, 1);
    chk("idle_busy", busy_o, 0);

    wq.delete();
    wq.push_back(64'h1122_3344_5566_7788);
    wq.push_back(64'hCAFE_BABE_DEAD_BEEF);
    do_write(64'h8000_0000, 2);
    do_read(64'h8000_0000, 2);

    exp_tx.push_back(8'h15);
    send_byte(8'h7F);
    wait_idle();
    new_words(1);
    do_write(64'h8000_0100, 1);

    do_write(64'h8000_0200, 0);
    new_words(2);
    do_write(64'hFFFF_FFFF_FFFF_FFF8, 2);
    do_read(64'hFFFF_FFFF_FFFF_FFF8, 2);

    tx_stall = 20;
    gnt_force = 5;
    do_read(64'h8000_0000, 2);
    gnt_force = -1;
    chk("stall_consumed", tx_stall, 0);

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 3);
      a = 64'h8000_0000 + 64'($urandom_range(0, 15) << 3) + 64'($urandom_range(0, 7));
      if (r == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h01 || b == 8'h02) b = 8'h7F;
        exp_tx.push_back(8'h15);
        send_byte(b);
        wait_idle();
      end else if (r <= 5) begin
        new_words(c);
        do_write(a, c);
      end else begin
        do_read(a, c);
      end
    end

    // Maximum COUNT: two words go through, then reset abandons the rest.
    new_words(2);
    expect_writes(64'h9000_0000, 2);
    send_hdr(8'h01, 64'h9000_0000, 32'hFFFF_FFFF);
    send_words(2);
    n = 0;
    while ((exp_ops.size() != 0 || mem_req_o || !rx_ready_o) && n < 2000) begin
      @(negedge clk_i); n++;
    end
    chk("maxcount_ops_done", exp_ops.size(), 0);
    chk("maxcount_still_busy", busy_o, 1);
    chk("maxcount_wants_data", rx_ready_o, 1);
    pulse_reset();

    // Reset in the middle of a read's data phase.
    push_read(64'h8000_0000, 3);
    send_hdr(8'h02, 64'h8000_0000, 32'd3);
    n = 0;
    while (exp_tx.size() > 20 && n < 2000) begin
      @(negedge clk_i); n++;
    end
    chk("midread_progress", exp_tx.size() <= 20, 1);
    pulse_reset();
    do_read(64'h8000_0000, 1);

`ifdef UART_DEBUG_RESPONDER_TIMEOUT_EN
    tx_stall = 1000;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    while (!tx_valid_o && n < 300) begin
      @(negedge clk_i); n++;
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_nak", tx_data_o, 8'h15);
    exp_tx.push_back(8'h15);
    tx_stall = 0;
    wait_idle();
    new_words(1);
    do_write(64'h8000_0300, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
